// File: rtl/fir_sample_feeder.sv
// Sample front end for the transposed-form FIR: valid/ready intake, one-cycle tap strobe,
// double-buffered coefficient bank. Defining FIR_FEEDER_FLUSH_EN adds i_flush and a FLUSH state.
module fir_sample_feeder #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_TAPS   = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_s_valid,
  output logic                           o_s_ready,
  input  logic [DATA_WIDTH-1:0]          iv_s_data,
  input  logic                           i_cw_valid,
  input  logic [ADDR_WIDTH-1:0]          iv_cw_addr,
  input  logic [DATA_WIDTH-1:0]          iv_cw_data,
  input  logic                           i_cw_commit,
`ifdef FIR_FEEDER_FLUSH_EN
  input  logic                           i_flush,
`endif
  output logic                           o_cw_err,
  output logic                           o_en,
  output logic [DATA_WIDTH-1:0]          ov_din,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_weights,
  output logic                           o_loaded
);

  // state | meaning
  // IDLE  | nothing committed since reset, samples refused
  // RUN   | streaming, samples accepted every cycle
  // SWAP  | single cycle, active bank loads from shadow bank
  // FLUSH | NUM_TAPS zero strobes to drain the tap chain (FIR_FEEDER_FLUSH_EN only)
`ifdef FIR_FEEDER_FLUSH_EN
  typedef enum logic [1:0] {IDLE, RUN, SWAP, FLUSH} state_t;
  localparam int CNT_WIDTH = $clog2(NUM_TAPS);
  logic [CNT_WIDTH-1:0] flush_cnt;
  logic                 commit_pend;
  logic                 flush_done;
`else
  typedef enum logic [1:0] {IDLE, RUN, SWAP} state_t;
`endif

  localparam logic [ADDR_WIDTH:0] TAPS = (ADDR_WIDTH+1)'(NUM_TAPS);

  state_t                        state;
  state_t                        next;
  logic [NUM_TAPS*DATA_WIDTH-1:0] shadow;
  logic                          accept;
  logic                          addr_ok;

  assign accept  = i_s_valid & o_s_ready;
  assign addr_ok = ({1'b0, iv_cw_addr} < TAPS);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= next;
  end

`ifdef FIR_FEEDER_FLUSH_EN
  assign flush_done = (flush_cnt == '0);
`endif

  always_comb begin
    next = state;
    case (state)
      IDLE: if (i_cw_commit) next = SWAP;
`ifdef FIR_FEEDER_FLUSH_EN
      RUN: begin
        if (i_flush)          next = FLUSH;
        else if (i_cw_commit) next = SWAP;
      end
      FLUSH: if (flush_done) next = (commit_pend | i_cw_commit) ? SWAP : RUN;
`else
      RUN: if (i_cw_commit) next = SWAP;
`endif
      SWAP: next = RUN;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    o_s_ready = 1'b0;
    if (state == RUN) o_s_ready = 1'b1;
  end

`ifdef FIR_FEEDER_FLUSH_EN
  // Down-counter spans the NUM_TAPS flush cycles; a commit seen meanwhile waits for the end.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      flush_cnt   <= '0;
      commit_pend <= 1'b0;
    end else begin
      if (state == RUN && next == FLUSH)    flush_cnt <= CNT_WIDTH'(NUM_TAPS - 1);
      else if (state == FLUSH && !flush_done) flush_cnt <= flush_cnt - 1'b1;
      if (next == FLUSH) commit_pend <= commit_pend | i_cw_commit;
      else               commit_pend <= 1'b0;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_en       <= 1'b0;
      ov_din     <= '0;
      o_cw_err   <= 1'b0;
      shadow     <= '0;
      ov_weights <= '0;
      o_loaded   <= 1'b0;
    end else begin
      o_en <= accept;
      if (accept) ov_din <= iv_s_data;
`ifdef FIR_FEEDER_FLUSH_EN
      if (state == FLUSH) begin
        o_en   <= 1'b1;
        ov_din <= '0;
      end
`endif
      o_cw_err <= i_cw_valid & ~addr_ok;
      for (int k = 0; k < NUM_TAPS; k++) begin
        if (i_cw_valid && addr_ok && iv_cw_addr == ADDR_WIDTH'(k))
          shadow[k*DATA_WIDTH +: DATA_WIDTH] <= iv_cw_data;
      end
      // Copies the pre-edge shadow, so a write landing in the SWAP cycle waits for the next commit.
      if (state == SWAP) begin
        ov_weights <= shadow;
        o_loaded   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Self-checking bench for fir_sample_feeder: directed scenarios plus random traffic against a
// behavioural bank/stream model. Flush scenarios run when FIR_FEEDER_FLUSH_EN is defined.
module tb_fir_sample_feeder;
  localparam int DW = 24;
  localparam int NT = 12;
  localparam int AW = 4;
  localparam int W  = NT*DW;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          cw_valid;
  logic [AW-1:0] cw_addr;
  logic [DW-1:0] cw_data;
  logic          cw_commit;
  logic          flush;
  logic          cw_err;
  logic          en;
  logic [DW-1:0] din;
  logic [W-1:0]  weights;
  logic          loaded;

  fir_sample_feeder #(.DATA_WIDTH(DW), .NUM_TAPS(NT), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_s_valid(s_valid), .o_s_ready(s_ready), .iv_s_data(s_data),
    .i_cw_valid(cw_valid), .iv_cw_addr(cw_addr), .iv_cw_data(cw_data), .i_cw_commit(cw_commit),
`ifdef FIR_FEEDER_FLUSH_EN
    .i_flush(flush),
`endif
    .o_cw_err(cw_err), .o_en(en), .ov_din(din), .ov_weights(weights), .o_loaded(loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 0;

  // Behavioural model: coefficient arrays plus a few flags describing what the feeder is doing.
  logic [DW-1:0] m_shadow [NT];
  logic [DW-1:0] m_active [NT];
  bit            m_started, m_swap, m_pend, m_en, m_err, m_loaded;
  int            m_flush_left;
  logic [DW-1:0] m_din;

  function automatic bit m_ready();
    return m_started && !m_swap && (m_flush_left == 0);
  endfunction

  function automatic logic [W-1:0] m_weights();
    logic [W-1:0] v;
    for (int k = 0; k < NT; k++) v[k*DW +: DW] = m_active[k];
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  task automatic model_update();
    bit acc;
    if (rst) begin
      m_started = 0; m_swap = 0; m_pend = 0; m_flush_left = 0;
      m_en = 0; m_din = '0; m_err = 0; m_loaded = 0;
      for (int k = 0; k < NT; k++) begin m_shadow[k] = '0; m_active[k] = '0; end
      return;
    end
    acc  = s_valid && m_ready();
    m_en = acc;
    if (acc) m_din = s_data;
    if (m_flush_left > 0) begin m_en = 1; m_din = '0; end
    m_err = cw_valid && (int'(cw_addr) >= NT);
    if (m_swap) begin
      for (int k = 0; k < NT; k++) m_active[k] = m_shadow[k];
      m_loaded = 1;
    end
    if (cw_valid && int'(cw_addr) < NT) m_shadow[int'(cw_addr)] = cw_data;
    if (m_swap) m_swap = 0;
    else if (m_flush_left > 0) begin
      m_flush_left--;
      m_pend = m_pend | cw_commit;
      if (m_flush_left == 0) begin m_swap = m_pend; m_pend = 0; end
    end else if (m_started && flush) begin
      m_flush_left = NT;
      m_pend = cw_commit;
    end else if (cw_commit) begin
      m_started = 1;
      m_swap = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic quiet();
    rst = 0; s_valid = 0; cw_valid = 0; cw_commit = 0; flush = 0;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("ready",   W'(s_ready), W'(m_ready()));
      check("en",      W'(en),      W'(m_en));
      check("din",     W'(din),     W'(m_din));
      check("cw_err",  W'(cw_err),  W'(m_err));
      check("weights", weights,     m_weights());
      check("loaded",  W'(loaded),  W'(m_loaded));
    end
  end

  initial begin
    logic [W-1:0] snap;
    s_data = '0; cw_addr = '0; cw_data = '0;
    quiet();
    rst = 1;
    step();
    chk_on = 1;

    // Samples refused until the first commit
    rst = 0; s_valid = 1; s_data = 24'h0ABCDE;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_ready", W'(s_ready), W'(0));
      check("idle_en", W'(en), W'(0));
      check("idle_weights", weights, W'(0));
    end

    // Load k*0x010000 and commit
    quiet();
    for (int k = 0; k < NT; k++) begin
      cw_valid = 1; cw_addr = AW'(k); cw_data = DW'(k * 32'h010000);
      step();
    end
    quiet(); cw_commit = 1;
    step();
    check("swap_ready", W'(s_ready), W'(0));
    check("swap_loaded", W'(loaded), W'(0));
    quiet();
    step();
    check("tap5", W'(weights[5*DW +: DW]), W'(24'h050000));
    check("loaded1", W'(loaded), W'(1));
    check("run_ready", W'(s_ready), W'(1));

    // Back-to-back stream
    s_valid = 1; s_data = 24'h400000; step();
    check("s0_en", W'(en), W'(1)); check("s0_din", W'(din), W'(24'h400000));
    s_data = 24'hC00000; step();
    check("s1_en", W'(en), W'(1)); check("s1_din", W'(din), W'(24'hC00000));
    s_data = 24'h7FFFFF; step();
    check("s2_en", W'(en), W'(1)); check("s2_din", W'(din), W'(24'h7FFFFF));
    s_valid = 0; step();
    check("s3_en", W'(en), W'(0)); check("s3_hold", W'(din), W'(24'h7FFFFF));

    // Shadow write while streaming; accept coincident with commit sees old tap3
    s_valid = 1; s_data = 24'h111111; cw_valid = 1; cw_addr = 3; cw_data = 24'h123456;
    step();
    check("tap3_old", W'(weights[3*DW +: DW]), W'(24'h030000));
    cw_valid = 0; s_data = 24'h222222; cw_commit = 1;
    step();
    check("cc_en", W'(en), W'(1));
    check("cc_din", W'(din), W'(24'h222222));
    check("cc_tap3", W'(weights[3*DW +: DW]), W'(24'h030000));
    quiet();
    step();
    check("tap3_new", W'(weights[3*DW +: DW]), W'(24'h123456));

    // Out-of-range write: one-cycle error, shadow untouched
    snap = weights;
    cw_valid = 1; cw_addr = 4'd15; cw_data = 24'hFFFFFF;
    step();
    check("err_pulse", W'(cw_err), W'(1));
    quiet();
    step();
    check("err_clear", W'(cw_err), W'(0));
    cw_commit = 1; step(); quiet(); step();
    check("err_no_write", weights, snap);

    // Reset mid-stream
    s_valid = 1; s_data = 24'h333333; step();
    rst = 1; cw_commit = 1; step();
    check("rst_ready", W'(s_ready), W'(0));
    check("rst_en", W'(en), W'(0));
    check("rst_din", W'(din), W'(0));
    check("rst_weights", weights, W'(0));
    check("rst_loaded", W'(loaded), W'(0));
    quiet();
    step();
    check("rst_pend_gone", W'(s_ready), W'(0));

`ifdef FIR_FEEDER_FLUSH_EN
    cw_valid = 1; cw_addr = 0; cw_data = 24'h0F0F0F; step();
    quiet(); cw_commit = 1; step(); quiet(); step();
    flush = 1; step(); flush = 0;
    cw_valid = 1; cw_addr = 1; cw_data = 24'h00AA00;
    for (int i = 0; i < NT; i++) begin
      cw_commit = (i == 5);
      step();
      cw_valid = 0;
      check("fl_ready", W'(s_ready), W'(0));
      check("fl_en", W'(en), W'(1));
      check("fl_din", W'(din), W'(0));
    end
    quiet();
    step();
    check("fl_after_ready", W'(s_ready), W'(1));
    check("fl_swap_tap1", W'(weights[1*DW +: DW]), W'(24'h00AA00));
`endif

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 400) == 0);
      s_valid   = ($urandom_range(0, 3) != 0);
      s_data    = DW'($urandom);
      cw_valid  = ($urandom_range(0, 3) == 0);
      cw_addr   = AW'($urandom_range(0, 15));
      cw_data   = DW'($urandom);
      cw_commit = ($urandom_range(0, 15) == 0);
`ifdef FIR_FEEDER_FLUSH_EN
      flush     = ($urandom_range(0, 60) == 0);
`else
      flush     = 0;
`endif
      step();
    end

    quiet();
    step();
    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
